// File: rtl/audio_fe_pkg.sv
// Shared types and helpers for the multi-channel codec audio front end.
// Sample helpers work on values sign-extended to MAX_W bits.
package audio_fe_pkg;

    typedef logic chan_t;

    localparam chan_t CH_LEFT  = 1'b0;
    localparam chan_t CH_RIGHT = 1'b1;

    localparam int MAX_W = 24;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rx_state_t;

    function automatic int decim_shift(input int d);
        return $clog2(d);
    endfunction

    // |x| for a w-bit two's complement value; the most negative code clamps.
    function automatic logic [MAX_W-1:0] abs_sat(
        input logic signed [MAX_W-1:0] x,
        input int                      w
    );
        int v;
        int lim;
        v   = int'(x);
        lim = (1 << (w - 1)) - 1;
        if (v < 0) begin
            v = -v;
        end
        if (v > lim) begin
            v = lim;
        end
        return MAX_W'(v);
    endfunction

endpackage

// File: rtl/audio_frontend_mc_i2s_lj_rx.sv
// Left-justified serial receiver: LRCK edge detect, MSB-first shift,
// word strobe on the W-th bit and a pulse when an edge cuts a word short.
module i2s_lj_rx
    import audio_fe_pkg::*;
#(
    parameter int W        = 16,
    parameter int CHANNELS = 1
) (
    input  logic         AUD_BCLK,
    input  logic         rst_n,
    input  logic         i_lrck,
    input  logic         i_dat,
    output logic         o_word_valid,
    output logic [W-1:0] o_word,
    output logic         o_chan,
    output logic         o_short_pulse
);

    localparam int CW = $clog2(W + 1);

    rx_state_t     r_state;
    rx_state_t     w_state_nx;
    logic          r_seen;
    logic          r_lrck_d;
    logic [CW-1:0] r_cnt;
    logic [W-2:0]  r_sh;
    chan_t         r_chan;
    logic          r_word_valid;
    logic [W-1:0]  r_word;
    chan_t         r_word_chan;
    logic          r_short;

    logic w_edge;
    logic w_take;
    logic w_last;

    // r_seen masks the level difference left over from reset
    assign w_edge = r_seen && (i_lrck != r_lrck_d);
    assign w_take = i_lrck || (CHANNELS == 2);
    assign w_last = (r_state == RX_SHIFT)
                 && (r_cnt == CW'(W - 1));

    always_ff @(posedge AUD_BCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_edge) begin
            w_state_nx = w_take ? RX_SHIFT : RX_IDLE;
        end else if (w_last) begin
            w_state_nx = RX_IDLE;
        end
    end

    always_ff @(posedge AUD_BCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_seen       <= 1'b0;
            r_lrck_d     <= 1'b0;
            r_cnt        <= '0;
            r_sh         <= '0;
            r_chan       <= CH_LEFT;
            r_word_valid <= 1'b0;
            r_word       <= '0;
            r_word_chan  <= CH_LEFT;
            r_short      <= 1'b0;
        end else begin
            r_seen       <= 1'b1;
            r_lrck_d     <= i_lrck;
            r_word_valid <= 1'b0;
            r_short      <= w_edge && (r_state == RX_SHIFT);
            if (w_edge) begin
                r_cnt  <= CW'(1);
                r_sh   <= (W-1)'(i_dat);
                r_chan <= i_lrck ? CH_LEFT : CH_RIGHT;
            end else if (r_state == RX_SHIFT) begin
                r_cnt <= r_cnt + 1'b1;
                r_sh  <= {r_sh[W-3:0], i_dat};
                if (w_last) begin
                    r_word_valid <= 1'b1;
                    r_word       <= {r_sh, i_dat};
                    r_word_chan  <= r_chan;
                end
            end
        end
    end

    assign o_word_valid  = r_word_valid;
    assign o_word        = r_word;
    assign o_chan        = r_word_chan;
    assign o_short_pulse = r_short;

endmodule

// File: rtl/audio_frontend_mc.sv
// Codec ADC front end: per-channel boxcar decimation, one-word output
// register with drop accounting, and per-channel peak-hold meters.
module audio_frontend_mc
    import audio_fe_pkg::*;
#(
    parameter int W           = 16,
    parameter int CHANNELS    = 1,
    parameter int DECIM       = 4,
    parameter int PEAK_HOLD   = 1024,
    parameter int DECAY_SHIFT = 4
) (
    input  logic                  AUD_BCLK,
    input  logic                  rst_n,
    input  logic                  adclrck,
    input  logic                  adcdat,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [W-1:0]          y_data,
    output logic                  y_chan,
    output logic [CHANNELS*W-1:0] peak_level,
    output logic [15:0]           overflow_cnt,
    output logic [15:0]           short_cnt
);

    localparam int DECIM_SHIFT = decim_shift(DECIM);
    localparam int AW = W + DECIM_SHIFT;
    localparam int CW = (DECIM_SHIFT > 0) ? DECIM_SHIFT : 1;
    localparam int HW = $clog2(PEAK_HOLD + 1);

    logic         w_word_valid;
    logic [W-1:0] w_word;
    chan_t        w_chan;
    logic         w_short;

    i2s_lj_rx #(
        .W        (W),
        .CHANNELS (CHANNELS)
    ) u_rx (
        .AUD_BCLK      (AUD_BCLK),
        .rst_n         (rst_n),
        .i_lrck        (adclrck),
        .i_dat         (adcdat),
        .o_word_valid  (w_word_valid),
        .o_word        (w_word),
        .o_chan        (w_chan),
        .o_short_pulse (w_short)
    );

    logic signed [W-1:0]  w_word_s;
    logic signed [AW-1:0] w_ext;
    logic [CHANNELS-1:0]  w_fire;
    logic [W-1:0]         w_mean [CHANNELS];
    logic [W-1:0]         w_sel;

    assign w_word_s = w_word;
    assign w_ext    = w_word_s;

    logic         r_dec_valid;
    logic [W-1:0] r_dec_data;
    chan_t        r_dec_chan;

    logic signed [W-1:0]     w_dec_s;
    logic signed [MAX_W-1:0] w_dec_x;
    logic [MAX_W-1:0]        w_abs;

    assign w_dec_s = r_dec_data;
    assign w_dec_x = w_dec_s;
    assign w_abs   = abs_sat(w_dec_x, W);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [AW-1:0] r_acc;
        logic [CW-1:0]        r_cnt;
        logic signed [AW-1:0] w_sum;
        logic signed [AW-1:0] w_shr;
        logic                 w_hit;

        assign w_hit = w_word_valid && (w_chan == chan_t'(c));
        assign w_sum = r_acc + w_ext;
        assign w_shr = w_sum >>> DECIM_SHIFT;
        assign w_mean[c] = W'(w_shr);
        assign w_fire[c] = w_hit
                        && (r_cnt == CW'(DECIM - 1));

        always_ff @(posedge AUD_BCLK or negedge rst_n) begin
            if (!rst_n) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_hit) begin
                if (w_fire[c]) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        logic [W-1:0]  r_peak;
        logic [HW-1:0] r_hold;
        logic [W-1:0]  w_step;
        logic          w_upd;

        // decay always makes progress, even when peak>>shift is zero
        assign w_step = ((r_peak >> DECAY_SHIFT) == '0)
                      ? W'(1) : (r_peak >> DECAY_SHIFT);
        assign w_upd  = r_dec_valid
                     && (r_dec_chan == chan_t'(c));

        always_ff @(posedge AUD_BCLK or negedge rst_n) begin
            if (!rst_n) begin
                r_peak <= '0;
                r_hold <= '0;
            end else if (w_upd) begin
                if (w_abs >= MAX_W'(r_peak)) begin
                    r_peak <= W'(w_abs);
                    r_hold <= HW'(PEAK_HOLD);
                end else if (r_hold != '0) begin
                    r_hold <= r_hold - 1'b1;
                end else if (r_peak != '0) begin
                    r_peak <= r_peak - w_step;
                end
            end
        end

        assign peak_level[c*W +: W] = r_peak;
    end

    always_comb begin
        w_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_fire[c]) begin
                w_sel = w_mean[c];
            end
        end
    end

    always_ff @(posedge AUD_BCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_valid <= 1'b0;
            r_dec_data  <= '0;
            r_dec_chan  <= CH_LEFT;
        end else begin
            r_dec_valid <= |w_fire;
            if (|w_fire) begin
                r_dec_data <= w_sel;
                r_dec_chan <= w_chan;
            end
        end
    end

    logic         r_y_valid;
    logic [W-1:0] r_y_data;
    chan_t        r_y_chan;
    logic [15:0]  r_ovf;
    logic [15:0]  r_short_cnt;

    // a word arriving on a handshake cycle replaces the departing one
    always_ff @(posedge AUD_BCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_y_valid   <= 1'b0;
            r_y_data    <= '0;
            r_y_chan    <= CH_LEFT;
            r_ovf       <= '0;
            r_short_cnt <= '0;
        end else begin
            if (r_dec_valid) begin
                if (!r_y_valid || y_ready) begin
                    r_y_valid <= 1'b1;
                    r_y_data  <= r_dec_data;
                    r_y_chan  <= r_dec_chan;
                end else if (r_ovf != 16'hFFFF) begin
                    r_ovf <= r_ovf + 16'd1;
                end
            end else if (r_y_valid && y_ready) begin
                r_y_valid <= 1'b0;
            end
            if (w_short && (r_short_cnt != 16'hFFFF)) begin
                r_short_cnt <= r_short_cnt + 16'd1;
            end
        end
    end

    assign y_valid      = r_y_valid;
    assign y_data       = r_y_data;
    assign y_chan       = r_y_chan;
    assign overflow_cnt = r_ovf;
    assign short_cnt    = r_short_cnt;

endmodule

// File: tb/tb_audio_frontend_mc.sv
// Directed bench for audio_frontend_mc: a mono /4 instance and a
// stereo pass-through instance driven from separate serial lines.
module tb_audio_frontend_mc;

    logic        clk;
    logic        rst_n;
    logic        lr0, dat0, rdy0;
    logic        lr1, dat1, rdy1;
    logic        y_valid0, y_chan0;
    logic        y_valid1, y_chan1;
    logic [15:0] y_data0, y_data1;
    logic [15:0] peak0;
    logic [31:0] peak1;
    logic [15:0] ovf0, ovf1, short0, short1;

    audio_frontend_mc #(
        .W(16), .CHANNELS(1), .DECIM(4),
        .PEAK_HOLD(2), .DECAY_SHIFT(4)
    ) u0 (
        .AUD_BCLK     (clk),
        .rst_n        (rst_n),
        .adclrck      (lr0),
        .adcdat       (dat0),
        .y_valid      (y_valid0),
        .y_ready      (rdy0),
        .y_data       (y_data0),
        .y_chan       (y_chan0),
        .peak_level   (peak0),
        .overflow_cnt (ovf0),
        .short_cnt    (short0)
    );

    audio_frontend_mc #(
        .W(16), .CHANNELS(2), .DECIM(1),
        .PEAK_HOLD(2), .DECAY_SHIFT(4)
    ) u1 (
        .AUD_BCLK     (clk),
        .rst_n        (rst_n),
        .adclrck      (lr1),
        .adcdat       (dat1),
        .y_valid      (y_valid1),
        .y_ready      (rdy1),
        .y_data       (y_data1),
        .y_chan       (y_chan1),
        .peak_level   (peak1),
        .overflow_cnt (ovf1),
        .short_cnt    (short1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] d;
        logic        c;
        int          cyc;
    } obs_t;

    obs_t q0[$];
    obs_t q1[$];
    int   lsb_cyc [2];

    // transfers seen after stimulus settles, before the next rising edge
    always @(negedge clk) begin
        #2;
        if (y_valid0 && rdy0) q0.push_back('{y_data0, y_chan0, cyc});
        if (y_valid1 && rdy1) q1.push_back('{y_data1, y_chan1, cyc});
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input int d, input logic lv,
                        input logic [15:0] w,
                        input int nb, input int pad);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            #1;
            if (d == 0) begin
                lr0  = lv;
                dat0 = w[15-i];
            end else begin
                lr1  = lv;
                dat1 = w[15-i];
            end
            if (i == 15) lsb_cyc[d] = cyc;
        end
        for (int i = 0; i < pad; i++) begin
            @(negedge clk);
            #1;
            if (d == 0) dat0 = 1'b0;
            else        dat1 = 1'b0;
        end
    endtask

    task automatic pull(input int d, output int n, output obs_t o);
        o = '{16'h0, 1'b0, 0};
        if (d == 0) begin
            n = q0.size();
            if (n > 0) o = q0.pop_front();
        end else begin
            n = q1.size();
            if (n > 0) o = q1.pop_front();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    typedef struct {
        int          d;
        logic        lv;
        logic [15:0] w;
        bit          has;
        logic [15:0] ey;
        logic        ec;
        logic [31:0] epk;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int d, input logic lv,
                       input logic [15:0] w, input bit has,
                       input logic [15:0] ey, input logic ec,
                       input logic [31:0] epk);
        vec_t v;
        v = '{d, lv, w, has, ey, ec, epk};
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        obs_t        o;
        int          n;
        logic [31:0] pk;

        // mono, /4: mean of 100..401 is 250; -1,-2,-2,-2 floors to -2
        add(0, 1, 16'd100, 0, 16'd0,   0, 32'd0);
        add(0, 0, 16'd0,   0, 16'd0,   0, 32'd0);
        add(0, 1, 16'd200, 0, 16'd0,   0, 32'd0);
        add(0, 0, 16'd0,   0, 16'd0,   0, 32'd0);
        add(0, 1, 16'd300, 0, 16'd0,   0, 32'd0);
        add(0, 0, 16'd0,   0, 16'd0,   0, 32'd0);
        add(0, 1, 16'd401, 1, 16'd250, 0, 32'd250);
        add(0, 0, 16'd0,   0, 16'd0,   0, 32'd250);
        add(0, 1, 16'hFFFF, 0, 16'd0,  0, 32'd250);
        add(0, 0, 16'd0,   0, 16'd0,   0, 32'd250);
        add(0, 1, 16'hFFFE, 0, 16'd0,  0, 32'd250);
        add(0, 0, 16'd0,   0, 16'd0,   0, 32'd250);
        add(0, 1, 16'hFFFE, 0, 16'd0,  0, 32'd250);
        add(0, 0, 16'd0,   0, 16'd0,   0, 32'd250);
        add(0, 1, 16'hFFFE, 1, 16'hFFFE, 0, 32'd250);
        // stereo pass-through: left peak 1600 holds, then 1500, 1407
        add(1, 1, 16'd1600, 1, 16'd1600, 0, 32'h0000_0640);
        add(1, 0, 16'd0, 1, 16'd0, 1, 32'h0000_0640);
        add(1, 1, 16'd0, 1, 16'd0, 0, 32'h0000_0640);
        add(1, 0, 16'd0, 1, 16'd0, 1, 32'h0000_0640);
        add(1, 1, 16'd0, 1, 16'd0, 0, 32'h0000_0640);
        add(1, 0, 16'd0, 1, 16'd0, 1, 32'h0000_0640);
        add(1, 1, 16'd0, 1, 16'd0, 0, 32'h0000_05DC);
        add(1, 0, 16'd0, 1, 16'd0, 1, 32'h0000_05DC);
        add(1, 1, 16'd0, 1, 16'd0, 0, 32'h0000_057F);
        add(1, 0, 16'h7FFF, 1, 16'h7FFF, 1, 32'h7FFF_057F);
        add(1, 1, 16'h8000, 1, 16'h8000, 0, 32'h7FFF_7FFF);

        rst_n = 1'b0;
        lr0 = 1'b0; dat0 = 1'b0; rdy0 = 1'b1;
        lr1 = 1'b0; dat1 = 1'b0; rdy1 = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        chk("rst_valid0", {31'd0, y_valid0}, 32'd0);
        chk("rst_data0",  {16'd0, y_data0},  32'd0);
        chk("rst_chan0",  {31'd0, y_chan0},  32'd0);
        chk("rst_peak0",  {16'd0, peak0},    32'd0);
        chk("rst_ovf0",   {16'd0, ovf0},     32'd0);
        chk("rst_short0", {16'd0, short0},   32'd0);
        chk("rst_valid1", {31'd0, y_valid1}, 32'd0);
        chk("rst_peak1",  peak1,             32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            send(v.d, v.lv, v.w, 16, 5);
            pull(v.d, n, o);
            chk($sformatf("v%0d_count", i), n, v.has ? 1 : 0);
            if (v.has && n > 0) begin
                chk($sformatf("v%0d_data", i), {16'd0, o.d}, {16'd0, v.ey});
                chk($sformatf("v%0d_chan", i), {31'd0, o.c}, {31'd0, v.ec});
                chk($sformatf("v%0d_latency", i),
                    o.cyc - lsb_cyc[v.d], 32'd3);
            end
            pk = (v.d == 0) ? {16'd0, peak0} : peak1;
            chk($sformatf("v%0d_peak", i), pk, v.epk);
        end
        chk("ovf0_ready_high", {16'd0, ovf0}, 32'd0);

        // right word cut after 9 bits, full left word follows
        send(1, 0, 16'hABCD, 9, 0);
        send(1, 1, 16'h1357, 16, 5);
        chk("short_cnt", {16'd0, short1}, 32'd1);
        pull(1, n, o);
        chk("short_next_count", n, 32'd1);
        chk("short_next_data", {16'd0, o.d}, 32'h1357);
        chk("short_next_chan", {31'd0, o.c}, 32'd0);

        // backpressure: second word dropped, first held
        rdy1 = 1'b0;
        send(1, 0, 16'h0011, 16, 5);
        send(1, 1, 16'h0022, 16, 5);
        chk("bp_valid", {31'd0, y_valid1}, 32'd1);
        chk("bp_data",  {16'd0, y_data1},  32'h0011);
        chk("bp_chan",  {31'd0, y_chan1},  32'd1);
        chk("bp_ovf",   {16'd0, ovf1},     32'd1);
        chk("bp_none",  q1.size(),         32'd0);
        rdy1 = 1'b1;
        idle(1);
        pull(1, n, o);
        chk("drain_count", n, 32'd1);
        chk("drain_data", {16'd0, o.d}, 32'h0011);
        chk("drain_valid_low", {31'd0, y_valid1}, 32'd0);

        // reset mid-accumulation and mid-word
        send(0, 0, 16'd0, 16, 5);
        send(0, 1, 16'd4, 16, 5);
        send(0, 0, 16'd0, 16, 5);
        send(0, 1, 16'd8, 16, 5);
        send(0, 0, 16'd0, 16, 5);
        send(0, 1, 16'h7777, 5, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid0", {31'd0, y_valid0}, 32'd0);
        chk("mid_rst_data0",  {16'd0, y_data0},  32'd0);
        chk("mid_rst_peak0",  {16'd0, peak0},    32'd0);
        chk("mid_rst_ovf1",   {16'd0, ovf1},     32'd0);
        chk("mid_rst_short1", {16'd0, short1},   32'd0);
        chk("mid_rst_chan1",  {31'd0, y_chan1},  32'd0);
        chk("mid_rst_peak1",  peak1,             32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        q0.delete();
        for (int k = 1; k <= 4; k++) begin
            send(0, 0, 16'd0, 16, 5);
            send(0, 1, 16'(4 * k), 16, 5);
            if (k < 4) begin
                chk($sformatf("post_rst_none%0d", k), q0.size(), 32'd0);
            end
        end
        pull(0, n, o);
        chk("post_rst_count", n, 32'd1);
        chk("post_rst_data", {16'd0, o.d}, 32'd10);
        chk("post_rst_chan", {31'd0, o.c}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
